spi_master_param: RTL and testbench

// - Parametrised SPI master; successor to the fixed 8-bit, mode-0, external-TICK SPI controller.
// - Adds configurable word width, internal SCLK divider, all four CPOL/CPHA modes, MSB/LSB-first order and N decoded chip selects.
// - Sits between a byte/word-level command FSM and the off-chip SPI pins.
// - Performs one full-duplex word per W_STB; returns the received word with a one-cycle R_STB.

---
 rtl/spi_master_param_pkg.sv | 21 ++
 rtl/spi_master_param_clk_div.sv | 32 +++
 rtl/spi_master_param.sv | 191 +++++++++++++++++++
 tb/tb_spi_master_param.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_param_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, SPI mode constants
// and the positions of CPOL/CPHA inside a 2-bit {CPOL,CPHA} mode word.
package spi_master_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_XFER  = 3'd2,
        ST_TRAIL = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_t;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_master_param_clk_div.sv
// Programmable tick generator: a one-cycle o_tick every (i_div+1) enabled cycles.
// The reload value is captured on i_load so the owner may change i_div afterwards.
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_reload;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt    <= '0;
            r_reload <= '0;
        end else if (i_load) begin
            r_cnt    <= i_div;
            r_reload <= i_div;
        end else if (i_en) begin
            r_cnt <= (r_cnt == '0) ? r_reload : r_cnt - 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: one DATA_W-bit word per accepted W_STB, any CPOL/CPHA,
// MSB/LSB first, N_CS decoded chip selects. Define SPI_LOOPBACK_EN to add the LOOPBACK input.
module spi_master_param
    import spi_master_param_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DIV_W  = 8,
    parameter  int N_CS   = 1,
    localparam int CS_W   = $clog2(N_CS > 1 ? N_CS : 2)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              W_STB,
    input  logic [DATA_W-1:0] W_DATA,
    input  logic [1:0]        W_MODE,
    input  logic              W_LSB,
    input  logic [CS_W-1:0]   W_CS,
    input  logic [DIV_W-1:0]  DIV,
    output logic              W_READY,
    output logic              R_STB,
    output logic [DATA_W-1:0] R_DATA,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
`ifdef SPI_LOOPBACK_EN
    input  logic              LOOPBACK,
`endif
    output logic [N_CS-1:0]   CS_N
);

    localparam int                EDGE_W    = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

    spi_state_t r_state;
    spi_state_t w_state_nxt;

    logic              r_cpha;
    logic              r_lsb;
    logic [CS_W-1:0]   r_cs;
    logic              r_sclk;
    logic              r_mosi;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rdata;
    logic [EDGE_W-1:0] r_edge;

    logic              w_ready;
    logic              w_active;
    logic              w_rstb;
    logic              w_accept;
    logic              w_tick;
    logic [EDGE_W-1:0] w_edge_num;
    logic              w_shift_edge;
    logic              w_din;
    logic [N_CS-1:0]   w_cs_n;

    // Bit that leaves the shifter next, and the shifter after it has gone (idle-high fill).
    function automatic logic f_first(input logic [DATA_W-1:0] data, input logic lsb);
        return lsb ? data[0] : data[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] f_shift(input logic [DATA_W-1:0] data, input logic lsb);
        return lsb ? {1'b1, data[DATA_W-1:1]} : {data[DATA_W-2:0], 1'b1};
    endfunction

    spi_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .CLK    (CLK),
        .RST    (RST),
        .i_load (w_accept),
        .i_en   (w_active),
        .i_div  (DIV),
        .o_tick (w_tick)
    );

    assign w_accept     = W_STB && w_ready;
    assign w_edge_num   = r_edge + EDGE_W'(1);
    // CPHA=0 shifts on even edges, CPHA=1 on odd edges; the other edges sample.
    assign w_shift_edge = (w_edge_num[0] == r_cpha);

`ifdef SPI_LOOPBACK_EN
    logic r_loopback;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_loopback <= 1'b0;
        end else if (w_accept) begin
            r_loopback <= LOOPBACK;
        end
    end

    assign w_din = r_loopback ? r_mosi : MISO;
`else
    assign w_din = MISO;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (W_STB) w_state_nxt = ST_LEAD;
            ST_LEAD:  if (w_tick) w_state_nxt = ST_XFER;
            ST_XFER:  if (w_tick && (w_edge_num == LAST_EDGE)) w_state_nxt = ST_TRAIL;
            ST_TRAIL: if (w_tick) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = W_STB ? ST_LEAD : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_ready  = 1'b0;
        w_active = 1'b0;
        w_rstb   = 1'b0;
        case (r_state)
            ST_IDLE:                    w_ready  = 1'b1;
            ST_LEAD, ST_XFER, ST_TRAIL: w_active = 1'b1;
            ST_DONE: begin
                w_ready = 1'b1;
                w_rstb  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_cs_n = '1;
        for (int i = 0; i < N_CS; i++) begin
            if (w_active && (r_cs == CS_W'(i))) w_cs_n[i] = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cpha  <= 1'b0;
            r_lsb   <= 1'b0;
            r_cs    <= '0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b1;
            r_tx    <= '0;
            r_rx    <= '0;
            r_edge  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_cpha <= W_MODE[CPHA_BIT];
                r_lsb  <= W_LSB;
                r_cs   <= W_CS;
                r_sclk <= W_MODE[CPOL_BIT];
                r_edge <= '0;
                r_rx   <= '0;
                // CPHA=0 must present the first bit before the first edge.
                if (W_MODE[CPHA_BIT]) begin
                    r_mosi <= 1'b1;
                    r_tx   <= W_DATA;
                end else begin
                    r_mosi <= f_first(W_DATA, W_LSB);
                    r_tx   <= f_shift(W_DATA, W_LSB);
                end
            end else if ((r_state == ST_XFER) && w_tick) begin
                r_edge <= w_edge_num;
                r_sclk <= ~r_sclk;
                if (w_shift_edge) begin
                    r_mosi <= f_first(r_tx, r_lsb);
                    r_tx   <= f_shift(r_tx, r_lsb);
                end else begin
                    r_rx <= r_lsb ? {w_din, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], w_din};
                end
            end
            if ((r_state == ST_TRAIL) && w_tick) begin
                r_rdata <= r_rx;
            end
        end
    end

    assign W_READY = w_ready;
    assign R_STB   = w_rstb;
    assign R_DATA  = r_rdata;
    assign SCLK    = r_sclk;
    assign MOSI    = w_active ? r_mosi : 1'b1;
    assign CS_N    = w_cs_n;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param (DATA_W=8, N_CS=4) with a mode-matched MSB-first slave model.
// Built with SPI_LOOPBACK_EN the last transfer also exercises LOOPBACK.
module tb_spi_master_param;
    import spi_master_param_pkg::*;

    logic       CLK    = 1'b0;
    logic       RST    = 1'b1;
    logic       W_STB  = 1'b0;
    logic [7:0] W_DATA = 8'h00;
    logic [1:0] W_MODE = 2'b00;
    logic       W_LSB  = 1'b0;
    logic [1:0] W_CS   = 2'd0;
    logic [7:0] DIV    = 8'd0;
    logic       MISO   = 1'b0;
`ifdef SPI_LOOPBACK_EN
    logic       LOOPBACK = 1'b0;
`endif
    logic       W_READY;
    logic       R_STB;
    logic [7:0] R_DATA;
    logic       SCLK;
    logic       MOSI;
    logic [3:0] CS_N;

    int n_checks = 0;
    int n_errors = 0;

    // Slave model state
    logic       t_cpol    = 1'b0;
    logic       t_cpha    = 1'b0;
    logic [7:0] slave_tx  = 8'h3C;
    logic [7:0] s_tx      = 8'h00;
    logic [7:0] s_rx      = 8'h00;
    int         s_edges   = 0;
    int         s_samples = 0;
    int         n_rstb    = 0;
    logic       cs_prev   = 1'b0;
    logic       sclk_prev = 1'b0;
    logic       cs_now;
    logic       lead_edge;

    spi_master_param #(
        .DATA_W (8),
        .DIV_W  (8),
        .N_CS   (4)
    ) u_dut (
        .CLK      (CLK),
        .RST      (RST),
        .W_STB    (W_STB),
        .W_DATA   (W_DATA),
        .W_MODE   (W_MODE),
        .W_LSB    (W_LSB),
        .W_CS     (W_CS),
        .DIV      (DIV),
        .W_READY  (W_READY),
        .R_STB    (R_STB),
        .R_DATA   (R_DATA),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
`ifdef SPI_LOOPBACK_EN
        .LOOPBACK (LOOPBACK),
`endif
        .CS_N     (CS_N)
    );

    always #5 CLK = ~CLK;

    // Slave watches the pins on the falling CLK edge, away from the DUT's update edge.
    always @(negedge CLK) begin
        cs_now = (CS_N != 4'hF);
        if (cs_now && !cs_prev) begin
            s_tx      = slave_tx;
            s_rx      = 8'h00;
            s_edges   = 0;
            s_samples = 0;
            if (!t_cpha) begin
                MISO = s_tx[7];
                s_tx = {s_tx[6:0], 1'b0};
            end
        end else if (cs_now && (SCLK !== sclk_prev)) begin
            s_edges   = s_edges + 1;
            lead_edge = (SCLK !== t_cpol);
            if (lead_edge ^ t_cpha) begin
                s_rx      = {s_rx[6:0], MOSI};
                s_samples = s_samples + 1;
            end else begin
                MISO = s_tx[7];
                s_tx = {s_tx[6:0], 1'b0};
            end
        end
        cs_prev   = cs_now;
        sclk_prev = SCLK;
        if (R_STB === 1'b1) n_rstb = n_rstb + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call mid-cycle; returns #1 after the accepting edge (cycle 1 of the transfer).
    task automatic start_xfer(input logic [7:0] data, input logic [1:0] mode, input logic lsb,
                              input logic [1:0] cs, input logic [7:0] div);
        W_DATA = data;
        W_MODE = mode;
        W_LSB  = lsb;
        W_CS   = cs;
        DIV    = div;
        t_cpol = mode[CPOL_BIT];
        t_cpha = mode[CPHA_BIT];
        W_STB  = 1'b1;
        @(posedge CLK);
        #1;
        W_STB  = 1'b0;
    endtask

    // Returns at the falling edge of the R_STB cycle; cyc is the cycle index counted from the accept.
    task automatic wait_done(input int limit, output int cyc);
        cyc = 1;
        @(negedge CLK);
        while ((R_STB !== 1'b1) && (cyc < limit)) begin
            @(posedge CLK);
            cyc++;
            @(negedge CLK);
        end
        check("rstb_seen", 32'(R_STB), 1);
    endtask

    initial begin
        int         cyc;
        logic [1:0] md;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready", 32'(W_READY), 1);
        check("rst_rstb",  32'(R_STB),   0);
        check("rst_rdata", 32'(R_DATA),  0);
        check("rst_sclk",  32'(SCLK),    0);
        check("rst_mosi",  32'(MOSI),    1);
        check("rst_cs_n",  32'(CS_N),    32'hF);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Mode 0, DIV=1: 0xA5 out, 0x3C back, R_STB in cycle 37
        slave_tx = 8'h3C;
        start_xfer(8'hA5, SPI_MODE0, 1'b0, 2'd0, 8'd1);
        check("m0_lead_ready", 32'(W_READY), 0);
        check("m0_lead_cs_n",  32'(CS_N),    32'hE);
        check("m0_lead_mosi",  32'(MOSI),    1);
        check("m0_lead_sclk",  32'(SCLK),    0);
        wait_done(100, cyc);
        check("m0_latency",   32'(cyc),       37);
        check("m0_rdata",     32'(R_DATA),    32'h3C);
        check("m0_mosi_bits", 32'(s_rx),      32'hA5);
        check("m0_samples",   32'(s_samples), 8);
        check("m0_done_cs_n", 32'(CS_N),      32'hF);
        check("m0_done_ready",32'(W_READY),   1);
        check("m0_done_mosi", 32'(MOSI),      1);
        @(negedge CLK);
        check("m0_rstb_width", 32'(R_STB),  0);
        check("m0_rdata_hold", 32'(R_DATA), 32'h3C);

        // Modes 1..3: SCLK jumps to the new CPOL in LEAD and idles there afterwards
        for (int m = 1; m < 4; m++) begin
            md = 2'(m);
            start_xfer(8'hA5, md, 1'b0, 2'd0, 8'd1);
            check("mx_lead_sclk", 32'(SCLK), 32'(md[1]));
            wait_done(100, cyc);
            check("mx_latency",   32'(cyc),       37);
            check("mx_rdata",     32'(R_DATA),    32'h3C);
            check("mx_mosi_bits", 32'(s_rx),      32'hA5);
            check("mx_samples",   32'(s_samples), 8);
            @(negedge CLK);
            check("mx_sclk_idle", 32'(SCLK), 32'(md[1]));
        end

        // LSB first, 0x01: first bit 1, slave (MSB-first) sees 0x80
        start_xfer(8'h01, SPI_MODE0, 1'b1, 2'd0, 8'd1);
        check("lsb_lead_mosi", 32'(MOSI), 1);
        check("lsb_lead_sclk", 32'(SCLK), 0);
        wait_done(100, cyc);
        check("lsb_slave_rx", 32'(s_rx),   32'h80);
        check("lsb_rdata",    32'(R_DATA), 32'h3C);
        @(negedge CLK);

        // Back-to-back accept in DONE, then an ignored W_STB mid-transfer
        n_rstb = 0;
        start_xfer(8'h96, SPI_MODE0, 1'b0, 2'd0, 8'd1);
        wait_done(100, cyc);
        check("b2b_first_rx",   32'(s_rx),   32'h96);
        check("b2b_done_cs_n",  32'(CS_N),   32'hF);
        start_xfer(8'h69, SPI_MODE0, 1'b0, 2'd0, 8'd1);
        check("b2b_accepted",   32'(W_READY), 0);
        check("b2b_lead_cs_n",  32'(CS_N),    32'hE);
        repeat (10) @(negedge CLK);
        W_DATA = 8'hFF;
        W_STB  = 1'b1;
        @(posedge CLK);
        #1;
        W_STB  = 1'b0;
        check("b2b_busy_ready", 32'(W_READY), 0);
        wait_done(100, cyc);
        check("b2b_second_rx",  32'(s_rx),   32'h69);
        check("b2b_rdata",      32'(R_DATA), 32'h3C);
        repeat (40) @(negedge CLK);
        check("b2b_rstb_count", 32'(n_rstb), 2);

        // Reset at SCLK edge 5 aborts the transfer
        n_rstb = 0;
        start_xfer(8'hA5, SPI_MODE0, 1'b0, 2'd0, 8'd1);
        @(negedge CLK);
        #1;
        cyc = 0;
        while ((s_edges < 5) && (cyc < 100)) begin
            @(negedge CLK);
            #1;
            cyc++;
        end
        check("abort_edge", 32'(s_edges), 5);
        RST = 1'b1;
        #1;
        check("abort_cs_n",  32'(CS_N),    32'hF);
        check("abort_ready", 32'(W_READY), 1);
        check("abort_rdata", 32'(R_DATA),  0);
        check("abort_rstb",  32'(R_STB),   0);
        check("abort_mosi",  32'(MOSI),    1);
        @(negedge CLK);
        RST = 1'b0;
        repeat (40) @(negedge CLK);
        check("abort_no_rstb", 32'(n_rstb), 0);

        // DIV=0, CS line 2, 0x5A: only CS_N[2] low, R_STB in cycle 19
`ifdef SPI_LOOPBACK_EN
        LOOPBACK = 1'b1;
        slave_tx = 8'hC3;
`else
        slave_tx = 8'h5A;
`endif
        start_xfer(8'h5A, SPI_MODE0, 1'b0, 2'd2, 8'd0);
        check("cs2_lead_cs_n", 32'(CS_N),    32'hB);
        check("cs2_ready",     32'(W_READY), 0);
        wait_done(100, cyc);
        check("cs2_latency",   32'(cyc),    19);
        check("cs2_rdata",     32'(R_DATA), 32'h5A);
        check("cs2_slave_rx",  32'(s_rx),   32'h5A);
        check("cs2_done_cs_n", 32'(CS_N),   32'hF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
